// File: rtl/wb_arbiter_if.sv
// Bus bundle for the two-master Wishbone arbiter.
// The "slave" modport is the arbiter's view: it takes requests from both
// masters and returns their acks and read data. It also drives the shared
// from_cpu port towards the WB_Bus decoder and receives that port's responses.
// The "master" modport is the environment's view: the masters plus the
// downstream slave.
interface wb_arbiter_if;
  logic [31:0] io_m0_addr;
  logic [31:0] io_m0_dat2;
  logic [31:0] io_m0_dat4;
  logic        io_m0_sel;
  logic        io_m0_we;
  logic        io_m0_ack;

  logic [31:0] io_m1_addr;
  logic [31:0] io_m1_dat2;
  logic [31:0] io_m1_dat4;
  logic        io_m1_sel;
  logic        io_m1_we;
  logic        io_m1_ack;

  logic [31:0] io_bus_addr;
  logic [31:0] io_bus_dat2;
  logic [31:0] io_bus_dat4;
  logic        io_bus_sel;
  logic        io_bus_we;
  logic        io_bus_ack;

  logic [1:0]  io_grant;
  logic        io_timeout;

  modport slave (
    input  io_m0_addr, io_m0_dat2, io_m0_sel, io_m0_we,
    input  io_m1_addr, io_m1_dat2, io_m1_sel, io_m1_we,
    input  io_bus_dat4, io_bus_ack,
    output io_m0_dat4, io_m0_ack, io_m1_dat4, io_m1_ack,
    output io_bus_addr, io_bus_dat2, io_bus_sel, io_bus_we,
    output io_grant, io_timeout
  );

  modport master (
    output io_m0_addr, io_m0_dat2, io_m0_sel, io_m0_we,
    output io_m1_addr, io_m1_dat2, io_m1_sel, io_m1_we,
    output io_bus_dat4, io_bus_ack,
    input  io_m0_dat4, io_m0_ack, io_m1_dat4, io_m1_ack,
    input  io_bus_addr, io_bus_dat2, io_bus_sel, io_bus_we,
    input  io_grant, io_timeout
  );
endinterface

// File: rtl/wb_arbiter.sv
// Two-master round-robin arbiter in front of the WB_Bus address decoder.
// m0 (instruction fetch) and m1 (data/DMA) share the single from_cpu port.
// A grant is held from sel until ack (or until the owner drops sel). Every
// transaction is followed by one IDLE cycle before the next grant.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to terminate a transaction
// that has gone TIMEOUT cycles without an ack. The terminated master gets
// TIMEOUT_DATA and an ack, and io_timeout pulses for that cycle.
module wb_arbiter #(
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  wb_arbiter_if.slave bus
);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;   // last master served; 1 after reset so m0 wins the first tie
  logic   own_sel;          // request line of the current owner
  logic   fire;             // watchdog terminates the current transaction this cycle

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_arbiter: TIMEOUT must be in 1..65535");
  end

  assign own_sel = (state_q == GNT0) ? bus.io_m0_sel :
                   (state_q == GNT1) ? bus.io_m1_sel : 1'b0;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] cnt_q, cnt_d;

  // A real ack in the same cycle wins over the watchdog; a dropped sel is an abort.
  assign fire = (state_q != IDLE) && own_sel && !bus.io_bus_ack && (cnt_q == CNT_LAST);
`else
  assign fire = 1'b0;
`endif

  // Next-state, round-robin memory and watchdog counter.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
`ifdef WB_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.io_m0_sel && (!bus.io_m1_sel || last_q)) begin
          state_d = GNT0;
        end else if (bus.io_m1_sel) begin
          state_d = GNT1;
        end
`ifdef WB_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      GNT0, GNT1: begin
        if (bus.io_bus_ack || fire) begin
          state_d = IDLE;
          last_d  = (state_q == GNT1);
        end else if (!own_sel) begin
          state_d = IDLE;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration FSM registers; reset returns to IDLE with m0 preferred.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Bus steering: the owner is wired straight through and everyone else sees zeros.
  always_comb begin
    bus.io_bus_addr = '0;
    bus.io_bus_dat2 = '0;
    bus.io_bus_sel  = 1'b0;
    bus.io_bus_we   = 1'b0;
    bus.io_m0_ack   = 1'b0;
    bus.io_m0_dat4  = '0;
    bus.io_m1_ack   = 1'b0;
    bus.io_m1_dat4  = '0;
    case (state_q)
      GNT0: begin
        bus.io_bus_addr = bus.io_m0_addr;
        bus.io_bus_dat2 = bus.io_m0_dat2;
        bus.io_bus_we   = bus.io_m0_we;
        bus.io_bus_sel  = bus.io_m0_sel & ~fire;
        bus.io_m0_ack   = bus.io_bus_ack | fire;
        bus.io_m0_dat4  = fire ? TIMEOUT_DATA : bus.io_bus_dat4;
      end
      GNT1: begin
        bus.io_bus_addr = bus.io_m1_addr;
        bus.io_bus_dat2 = bus.io_m1_dat2;
        bus.io_bus_we   = bus.io_m1_we;
        bus.io_bus_sel  = bus.io_m1_sel & ~fire;
        bus.io_m1_ack   = bus.io_bus_ack | fire;
        bus.io_m1_dat4  = fire ? TIMEOUT_DATA : bus.io_bus_dat4;
      end
      default: ;
    endcase
  end

  assign bus.io_grant   = state_q;
  assign bus.io_timeout = fire;

endmodule
